// File: rtl/ball_motion_logic.sv
// Ball motion: latches a cue-shot velocity while at rest, then per frame integrates
// position, bounces off the cushions and applies friction. Optional macro: BALL_VELOCITY_CLAMP_EN.
module ball_motion_logic #(
  parameter int INIT_X          = 320,
  parameter int INIT_Y          = 240,
  parameter int FRAC_BITS       = 4,
  parameter int LEFT_BORDER     = 32,
  parameter int RIGHT_BORDER    = 607,
  parameter int TOP_BORDER      = 32,
  parameter int BOTTOM_BORDER   = 447,
  parameter int BALL_SIZE       = 16,
  parameter int FRICTION_PERIOD = 4,
  parameter int MAX_SPEED       = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic signed [10:0] newVelocityX,
  input  logic signed [10:0] newVelocityY,
  input  logic               velocityWriteEnable,
  output logic        [10:0] topLeftX,
  output logic        [10:0] topLeftY,
  output logic               ballMoving,
  output logic               writeAccepted,
  output logic               writeRejected,
  output logic               ballStopped
);

  localparam int PW = 11 + FRAC_BITS;
  localparam int SW = PW + 2;
  localparam int IW = SW - FRAC_BITS;
  localparam int CW = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

  localparam logic signed [IW-1:0] X_MIN = IW'(LEFT_BORDER);
  localparam logic signed [IW-1:0] X_MAX = IW'(RIGHT_BORDER - BALL_SIZE + 1);
  localparam logic signed [IW-1:0] Y_MIN = IW'(TOP_BORDER);
  localparam logic signed [IW-1:0] Y_MAX = IW'(BOTTOM_BORDER - BALL_SIZE + 1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(FRICTION_PERIOD - 1);
  localparam logic signed [10:0]   V_LIM = 11'(MAX_SPEED);

  typedef enum logic {IDLE, MOVING} state_t;

  state_t             state;
  logic [PW-1:0]      posX, posY;
  logic signed [10:0] velX, velY;
  logic [CW-1:0]      frictionCnt;

  logic [PW-1:0]      nextPosX, nextPosY;
  logic signed [10:0] bounceVelX, bounceVelY;
  logic signed [10:0] nextVelX, nextVelY;
  logic signed [10:0] acceptX, acceptY;
  logic               cntWrap;

  function automatic logic signed [10:0] negSat(input logic signed [10:0] v);
    return (v == -11'sd1024) ? 11'sd1023 : -v;
  endfunction

  function automatic logic signed [10:0] towardZero(input logic signed [10:0] v);
    if (v > 11'sd0) return v - 11'sd1;
    if (v < 11'sd0) return v + 11'sd1;
    return v;
  endfunction

  function automatic logic signed [10:0] clampVel(input logic signed [10:0] v);
`ifdef BALL_VELOCITY_CLAMP_EN
    if (v > V_LIM) return V_LIM;
    if (v < -V_LIM) return -V_LIM;
    return v;
`else
    return v;
`endif
  endfunction

  // One axis: integrate, then snap to the cushion and reverse if the ball crossed it.
  function automatic void stepAxis(
    input  logic [PW-1:0]      pos,
    input  logic signed [10:0] vel,
    input  logic signed [IW-1:0] lo,
    input  logic signed [IW-1:0] hi,
    output logic [PW-1:0]      nPos,
    output logic signed [10:0] nVel
  );
    logic signed [SW-1:0] sum;
    logic signed [IW-1:0] ipart;
    sum   = $signed({2'b00, pos}) + SW'(vel);
    ipart = sum[SW-1:FRAC_BITS];
    nPos  = sum[PW-1:0];
    nVel  = vel;
    if (ipart < lo) begin
      nPos = {lo[10:0], {FRAC_BITS{1'b0}}};
      nVel = negSat(vel);
    end else if (ipart > hi) begin
      nPos = {hi[10:0], {FRAC_BITS{1'b0}}};
      nVel = negSat(vel);
    end
  endfunction

  always_comb begin
    nextPosX   = '0;
    nextPosY   = '0;
    bounceVelX = '0;
    bounceVelY = '0;
    stepAxis(posX, velX, X_MIN, X_MAX, nextPosX, bounceVelX);
    stepAxis(posY, velY, Y_MIN, Y_MAX, nextPosY, bounceVelY);
    cntWrap  = (frictionCnt == CNT_LAST);
    nextVelX = cntWrap ? towardZero(bounceVelX) : bounceVelX;
    nextVelY = cntWrap ? towardZero(bounceVelY) : bounceVelY;
    acceptX  = clampVel(newVelocityX);
    acceptY  = clampVel(newVelocityY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      posX          <= {11'(INIT_X), {FRAC_BITS{1'b0}}};
      posY          <= {11'(INIT_Y), {FRAC_BITS{1'b0}}};
      velX          <= '0;
      velY          <= '0;
      frictionCnt   <= '0;
      ballMoving    <= 1'b0;
      writeAccepted <= 1'b0;
      writeRejected <= 1'b0;
      ballStopped   <= 1'b0;
    end else begin
      writeAccepted <= 1'b0;
      writeRejected <= 1'b0;
      ballStopped   <= 1'b0;
      case (state)
        IDLE: begin
          // startOfFrame has no effect at rest, even when it coincides with a write.
          if (velocityWriteEnable) begin
            velX          <= acceptX;
            velY          <= acceptY;
            frictionCnt   <= '0;
            writeAccepted <= 1'b1;
            if (acceptX != 11'sd0 || acceptY != 11'sd0) begin
              state      <= MOVING;
              ballMoving <= 1'b1;
            end
          end
        end
        MOVING: begin
          if (velocityWriteEnable) writeRejected <= 1'b1;
          if (startOfFrame) begin
            posX        <= nextPosX;
            posY        <= nextPosY;
            velX        <= nextVelX;
            velY        <= nextVelY;
            frictionCnt <= cntWrap ? '0 : frictionCnt + CW'(1);
            if (nextVelX == 11'sd0 && nextVelY == 11'sd0) begin
              state       <= IDLE;
              ballMoving  <= 1'b0;
              ballStopped <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign topLeftX = posX[PW-1:FRAC_BITS];
  assign topLeftY = posY[PW-1:FRAC_BITS];

endmodule

// File: tb/tb_ball_motion_logic.sv
// Bench for ball_motion_logic: a behavioural model predicts every output cycle,
// results queued at drive time and compared one clock later.
module tb_ball_motion_logic;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               startOfFrame = 1'b0;
  logic signed [10:0] newVelocityX = '0;
  logic signed [10:0] newVelocityY = '0;
  logic               velocityWriteEnable = 1'b0;
  logic        [10:0] topLeftX, topLeftY;
  logic               ballMoving, writeAccepted, writeRejected, ballStopped;

  ball_motion_logic dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .newVelocityX(newVelocityX), .newVelocityY(newVelocityY),
    .velocityWriteEnable(velocityWriteEnable),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .ballMoving(ballMoving),
    .writeAccepted(writeAccepted), .writeRejected(writeRejected),
    .ballStopped(ballStopped)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [25:0] exp_q[$];

  // model state: position in 1/16 pixel
  int  m_x, m_y, m_vx, m_vy, m_cnt;
  bit  m_mov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int neg_sat(int v);
    return (v == -1024) ? 1023 : -v;
  endfunction

  function automatic int to_zero(int v);
    return (v > 0) ? v - 1 : (v < 0) ? v + 1 : 0;
  endfunction

  function automatic int clamp_v(int v);
`ifdef BALL_VELOCITY_CLAMP_EN
    if (v > 256) return 256;
    if (v < -256) return -256;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_x = 320 * 16; m_y = 240 * 16; m_vx = 0; m_vy = 0; m_cnt = 0; m_mov = 0;
  endtask

  task automatic model_axis(inout int p, inout int v, input int lo, input int hi_edge);
    p += v;
    if ((p >>> 4) < lo) begin
      p = lo * 16; v = neg_sat(v);
    end else if ((p >>> 4) + 15 > hi_edge) begin
      p = (hi_edge - 15) * 16; v = neg_sat(v);
    end
  endtask

  // drive one cycle, predict the outputs it produces, then compare them
  task automatic cyc(input bit sof, input bit we, input int vx, input int vy);
    bit acc, rej, stp;
    logic [25:0] e;
    acc = 0; rej = 0; stp = 0;
    startOfFrame = sof; velocityWriteEnable = we;
    newVelocityX = 11'(vx); newVelocityY = 11'(vy);
    if (!m_mov) begin
      if (we) begin
        m_vx = clamp_v(vx); m_vy = clamp_v(vy); m_cnt = 0; acc = 1;
        m_mov = (m_vx != 0 || m_vy != 0);
      end
    end else begin
      rej = we;
      if (sof) begin
        model_axis(m_x, m_vx, 32, 607);
        model_axis(m_y, m_vy, 32, 447);
        m_cnt = (m_cnt + 1) % 4;
        if (m_cnt == 0) begin m_vx = to_zero(m_vx); m_vy = to_zero(m_vy); end
        if (m_vx == 0 && m_vy == 0) begin m_mov = 0; stp = 1; end
      end
    end
    exp_q.push_back({11'(m_x >>> 4), 11'(m_y >>> 4), m_mov, acc, rej, stp});
    @(posedge clk); #1;
    startOfFrame = 1'b0; velocityWriteEnable = 1'b0;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("topLeftX", 32'(topLeftX), 32'(e[25:15]));
      check("topLeftY", 32'(topLeftY), 32'(e[14:4]));
      check("ballMoving", 32'(ballMoving), 32'(e[3]));
      check("writeAccepted", 32'(writeAccepted), 32'(e[2]));
      check("writeRejected", 32'(writeRejected), 32'(e[1]));
      check("ballStopped", 32'(ballStopped), 32'(e[0]));
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic run_until_stop(input int max_frames);
    int n;
    n = 0;
    while (m_mov && n < max_frames) begin
      frames(1);
      n++;
    end
    check("stop_budget", 32'(ballMoving), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, 32'(topLeftX), 32'd320);
    check({tag, "_y"}, 32'(topLeftY), 32'd240);
    check({tag, "_moving"}, 32'(ballMoving), 32'd0);
    check({tag, "_pulses"}, 32'({writeAccepted, writeRejected, ballStopped}), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 check_reset_values("reset");
    @(posedge clk); #1 reset = 1'b0;
    model_reset();

    // at rest frames do nothing
    frames(3);
    check_reset_values("idle_frames");

    // basic shot along X
    cyc(0, 1, 32, 0);
    check("accept_pulse", 32'(writeAccepted), 32'd1);
    check("accept_moving", 32'(ballMoving), 32'd1);
    frames(1);
    check("x_after_1", 32'(topLeftX), 32'd322);
    frames(3);
    check("x_after_4", 32'(topLeftX), 32'd328);
    cyc(0, 1, 5, 5);
    check("reject_pulse", 32'(writeRejected), 32'd1);
    frames(2);
    check("x_after_6", 32'(topLeftX), 32'd331);
    run_until_stop(400);

    // tiny shot: friction stops it on the 4th frame
    cyc(0, 1, 1, 0);
    frames(3);
    check("slow_moving", 32'(ballMoving), 32'd1);
    cyc(1, 0, 0, 0);
    check("slow_stop_pulse", 32'(ballStopped), 32'd1);
    check("slow_stopped", 32'(ballMoving), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("zero_accept", 32'(writeAccepted), 32'd1);
    check("zero_idle", 32'(ballMoving), 32'd0);
    frames(2);

    // write coincident with a frame in IDLE: no step that frame
    cyc(1, 1, 40, -24);
    frames(5);

    // full-speed shots into the cushions, including -1024 negation
    run_until_stop(4200);
    cyc(0, 1, 1023, -1023);
    run_until_stop(4200);
    cyc(0, 1, -1024, 0);
    frames(40);

    // asynchronous reset mid-motion
    #2 reset = 1'b1;
    #1 check_reset_values("mid_reset");
    @(posedge clk); #1 reset = 1'b0;
    model_reset();

    // large negative request, clamped when the feature is built in
    cyc(0, 1, -1000, 700);
    frames(6);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
